bcd_display_scanner: RTL and testbench
======================================

// Module: bcd_display_scanner
// PURPOSE
//  Time-multiplexed driver for a NUM_DIGITS common-anode 7-segment display.
//  Sits directly upstream of the BCD-to-7-segment decode stage.
//  Buffers a packed multi-digit BCD word and scans one digit per slot.
//  Each digit's nibble is decoded to segments a..g and driven with its
//  active-low anode enable.
// PARAMETERS
//  NUM_DIGITS  4      digits scanned, 2..8
//  PRESCALE    50000  clk cycles per digit slot, > BLANK_CYC+1
//  BLANK_CYC   16     cycles at slot start with all anodes off (anti-ghost)
// PORTS
//  clk         in   1             single clock, rising edge
//  rst         in   1             asynchronous, active-high reset
//  en          in   1             1 = scan, 0 = display dark
//  load        in   1             1-cycle strobe: capture bcd_in/dp_in
//  bcd_in      in   4*NUM_DIGITS  digit i = bcd_in[4i+3:4i]; digit 0 = rightmost
//  dp_in       in   NUM_DIGITS    decimal point per digit
//  digit_bcd   out  4             BCD nibble of the active digit (to decoder)
//  seg         out  7             {a,b,c,d,e,f,g}, 1 = lit
//  dp          out  1             1 = lit
//  an          out  NUM_DIGITS    anode enables, active-low, one-hot-low
//  frame_done  out  1             1-cycle pulse when the last digit slot ends
// BEHAVIOUR
//  - Reset: state IDLE, idx=0, presc=0, staging/display regs=0.
//    Outputs after reset: an all 1, seg=0, dp=0, digit_bcd=0, frame_done=0.
//  - All outputs are registered. Segment/anode outputs lag the state by 1 clk.
//  - FSM states: IDLE, BLANK, DRIVE.
//    IDLE -en-> BLANK: idx=0, presc=0, display<=staging.
//    BLANK: an all 1, seg=0. When presc==BLANK_CYC-1, go to DRIVE.
//    DRIVE: an[idx]=0, seg=decode(display[idx]), dp=display_dp[idx].
//    DRIVE, presc==PRESCALE-1: presc<=0, idx<=idx+1, go to BLANK.
//  - Wrap: idx==NUM_DIGITS-1 at slot end -> idx<=0 and frame_done=1 for 1 clk.
//  - en=0 in any state -> next edge IDLE; presc and idx cleared; outputs dark.
//  - Buffering:
//    load -> staging<=bcd_in, dp_in on that edge.
//    staging -> display only at frame wrap or on IDLE->BLANK (no tearing).
//    load on the wrap edge -> display<=bcd_in directly; staging also updated.
//  - Nibble 10..15 -> seg=0 (blank); dp is still honoured.
//    digit_bcd outputs the raw nibble.
//  - presc width = $clog2(PRESCALE); idx width = $clog2(NUM_DIGITS).
//    Both wrap explicitly, never by overflow.
//  - rst asserted mid-frame -> immediate dark outputs.
//    After release, IDLE until en=1.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//    Zeros above the most-significant nonzero digit show seg=0.
//    Digit 0 always shows. dp is unaffected.
//    The mask is computed from display at each transfer.
//  LEADING_ZERO_BLANK_EN undefined: every digit is shown as stored.
// STRUCTURE
//  Package bcd_disp_pkg:
//    typedef enum logic[1:0] {IDLE,BLANK,DRIVE} scan_state_t.
//    localparam SEG_BLANK=7'b0.
//    Function bcd_digit(word,idx).
//  Sub-module bcd_seg_lut: combinational nibble -> {a..g}; 10..15 -> SEG_BLANK.
//  Top: FSM, prescaler, index counter, staging/display regs, output regs.
// TESTING (NUM_DIGITS=4, PRESCALE=8, BLANK_CYC=2)
//  1. rst pulse mid-DRIVE -> same cycle an=4'b1111, seg=0; IDLE until en.
//  2. load bcd_in=16'h1234, en=1:
//     an cycles 1110,1101,1011,0111, 8 clk each.
//     seg: 4->0110011, 3->1111001, 2->1101101, 1->0110000.
//     First 2 clk of each slot are dark.
//     frame_done pulses once per 32 clk.
//  3. load 16'h5678 mid-frame -> rest of frame still shows 1234;
//     5678 from the next frame. load on the wrap edge -> new value immediately.
//  4. bcd_in=16'hF0A9 -> digits 0,1,2,3 show 9, blank, 0, blank;
//     digit_bcd shows 9, A, 0, F.
//  5. en low for 3 clk mid-frame -> an=1111 from the next edge;
//     re-enable restarts at idx 0 with BLANK.
//  6. LEADING_ZERO_BLANK_EN, bcd_in=16'h0040 -> digits 3 and 0 blank... no:
//     digit 3 blank, digit 2 blank? -> digits 3 and 2 dark, digit 1 shows 4,
//     digit 0 shows 0. bcd_in=16'h0000 -> only digit 0 shows 0.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared types and helpers for the multiplexed BCD display scanner.
// Latency: none (declarations and pure functions only).
// Backpressure: none (no handshake).
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    // All segments off. Used for dark slots and for non-decimal nibbles.
    localparam logic [6:0] SEG_BLANK = 7'b0;

    // Extract digit idx from a packed BCD word.
    // The word is zero-extended to 32 bits by the caller, so up to 8 digits fit.
    function automatic logic [3:0] bcd_digit(input logic [31:0] word, input int idx);
        return word[4*idx +: 4];
    endfunction

endpackage

// File: rtl/bcd_seg_lut.sv
// BCD nibble to 7-segment pattern {a,b,c,d,e,f,g}, 1 = lit; 10..15 decode dark.
// Latency: combinational.
// Backpressure: none.
// Ports: nibble (in, 4) BCD digit; seg (out, 7) segment pattern.
module bcd_seg_lut
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'd0: seg = 7'b1111110;
            4'd1: seg = 7'b0110000;
            4'd2: seg = 7'b1101101;
            4'd3: seg = 7'b1111001;
            4'd4: seg = 7'b0110011;
            4'd5: seg = 7'b1011011;
            4'd6: seg = 7'b1011111;
            4'd7: seg = 7'b1110000;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1111011;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-anode 7-segment driver: one digit per PRESCALE-cycle slot,
// first BLANK_CYC cycles of each slot dark. Latency: outputs registered, 1 clk after state.
// Backpressure: none; load is a fire-and-forget strobe, new data shown from the next frame.
// Ports: clk, rst (async, active-high), en, load, bcd_in[4*NUM_DIGITS], dp_in[NUM_DIGITS]
//        -> digit_bcd[4], seg[7] {a..g}, dp, an[NUM_DIGITS] (active-low), frame_done (pulse).
// Optional build macro: LEADING_ZERO_BLANK_EN blanks zeros above the most-significant
// nonzero digit (digit 0 always shown, dp unaffected).
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [3:0]              digit_bcd,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    scan_state_t state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [IW-1:0] idx, idx_nxt;

    logic [4*NUM_DIGITS-1:0] staging, display;
    logic [NUM_DIGITS-1:0]   staging_dp, display_dp, blank_mask;

    logic                    slot_end, wrap, xfer, drive_now;
    logic [4*NUM_DIGITS-1:0] xfer_word;
    logic [NUM_DIGITS-1:0]   xfer_dp, xfer_mask;
    logic [3:0]              cur_nib;
    logic [6:0]              lut_seg;

    assign slot_end  = (state == DRIVE) && (presc == PRESC_LAST);
    assign wrap      = slot_end && (idx == IDX_LAST);
    // Display only changes between frames so a frame never mixes two values.
    assign xfer      = en && ((state == IDLE) || wrap);
    // A load coinciding with the transfer bypasses staging so it shows immediately.
    assign xfer_word = load ? bcd_in : staging;
    assign xfer_dp   = load ? dp_in  : staging_dp;
    assign drive_now = en && (state == DRIVE);
    assign cur_nib   = bcd_digit(32'(display), int'(idx));

`ifdef LEADING_ZERO_BLANK_EN
    // Digit i is blanked when it and every digit above it are zero; digit 0 never.
    always_comb begin
        logic zero_above;
        xfer_mask  = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above && (bcd_digit(32'(xfer_word), i) == 4'd0);
            xfer_mask[i] = zero_above;
        end
    end
`else
    assign xfer_mask = '0;
`endif

    bcd_seg_lut u_seg_lut (
        .nibble (cur_nib),
        .seg    (lut_seg)
    );

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        idx_nxt   = idx;
        if (!en) begin
            state_nxt = IDLE;
            presc_nxt = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    presc_nxt = '0;
                    idx_nxt   = '0;
                end
                BLANK: begin
                    presc_nxt = presc + 1'b1;
                    if (presc == BLANK_LAST) state_nxt = DRIVE;
                end
                DRIVE: begin
                    if (slot_end) begin
                        state_nxt = BLANK;
                        presc_nxt = '0;
                        idx_nxt   = wrap ? '0 : idx + 1'b1;
                    end else begin
                        presc_nxt = presc + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    presc_nxt = '0;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            presc <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            presc <= presc_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging    <= '0;
            staging_dp <= '0;
            display    <= '0;
            display_dp <= '0;
            blank_mask <= '0;
        end else begin
            if (load) begin
                staging    <= bcd_in;
                staging_dp <= dp_in;
            end
            if (xfer) begin
                display    <= xfer_word;
                display_dp <= xfer_dp;
                blank_mask <= xfer_mask;
            end
        end
    end

    // Outputs reflect the state of the previous cycle; en low darkens them at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b0;
            digit_bcd  <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            an         <= drive_now ? ~(NUM_DIGITS'(1) << idx) : '1;
            seg        <= (drive_now && !blank_mask[idx]) ? lut_seg : SEG_BLANK;
            dp         <= drive_now && display_dp[idx];
            digit_bcd  <= drive_now ? cur_nib : 4'd0;
            frame_done <= en && wrap;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: directed scenarios plus random load/en traffic
// compared each cycle against a time-based behavioural model.
// Latency/backpressure: n/a (bench).
module tb_bcd_display_scanner;

    localparam int ND    = 4;
    localparam int PS    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * PS;

    logic          clk = 1'b0;
    logic          rst, en, load;
    logic [15:0]   bcd_in;
    logic [3:0]    dp_in;
    logic [3:0]    digit_bcd;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_done;

    bcd_display_scanner #(.NUM_DIGITS(ND), .PRESCALE(PS), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .digit_bcd  (digit_bcd),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: the scan is a pure function of cycles elapsed since the enable edge.
    bit          scanning;
    int          n;
    logic [15:0] m_stage, m_disp;
    logic [3:0]  m_stage_dp, m_disp_dp;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
        return (v < 10) ? tbl[v] : 7'b0;
    endfunction

    task automatic model_reset();
        scanning   = 0;
        n          = 0;
        m_stage    = '0;
        m_disp     = '0;
        m_stage_dp = '0;
        m_disp_dp  = '0;
    endtask

    // One clock: predict outputs, advance model, then sample at the falling edge.
    task automatic tick();
        logic [3:0] e_an, e_bcd, nib;
        logic [6:0] e_seg;
        logic       e_dp, e_fd;
        int         pos, dig;
        e_an = 4'hF; e_seg = '0; e_dp = 1'b0; e_bcd = '0; e_fd = 1'b0;
        if (en && scanning) begin
            pos = n % PS;
            dig = (n / PS) % ND;
            nib = m_disp[4*dig +: 4];
            if (pos >= BC) begin
                e_an  = ~(4'b0001 << dig);
                e_bcd = nib;
                e_dp  = m_disp_dp[dig];
                e_seg = seg_of(nib);
`ifdef LEADING_ZERO_BLANK_EN
                if (dig != 0 && (m_disp >> (4*dig)) == 16'd0) e_seg = '0;
`endif
            end
            e_fd = ((n % FRAME) == FRAME - 1);
        end
        if (!en) begin
            scanning = 0;
        end else if (!scanning) begin
            scanning  = 1;
            n         = 0;
            m_disp    = load ? bcd_in : m_stage;
            m_disp_dp = load ? dp_in  : m_stage_dp;
        end else begin
            if ((n % FRAME) == FRAME - 1) begin
                m_disp    = load ? bcd_in : m_stage;
                m_disp_dp = load ? dp_in  : m_stage_dp;
            end
            n++;
        end
        if (load) begin
            m_stage    = bcd_in;
            m_stage_dp = dp_in;
        end
        @(posedge clk);
        @(negedge clk);
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("digit_bcd", 32'(digit_bcd), 32'(e_bcd));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic load_word(input logic [15:0] w, input logic [3:0] d);
        bcd_in = w;
        dp_in  = d;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    task automatic run_to_wrap_edge();
        int guard = 0;
        while (!(scanning && en && (n % FRAME) == FRAME - 1) && guard < 4 * FRAME) begin
            tick();
            guard++;
        end
        chk("wrap_reach", 32'(n % FRAME), 32'(FRAME - 1));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; bcd_in = '0; dp_in = '0;
        model_reset();
        #12;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_bcd", 32'(digit_bcd), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();

        // Basic scan of 1234 with one decimal point.
        en = 1'b1;
        load_word(16'h1234, 4'b0100);
        repeat (40) tick();

        // Mid-frame load is deferred; a load on the wrap edge shows immediately.
        load_word(16'h5678, 4'b0001);
        repeat (5) tick();
        run_to_wrap_edge();
        load_word(16'h9012, 4'b1000);
        repeat (FRAME + 4) tick();

        // Non-decimal nibbles decode dark but pass through on digit_bcd.
        load_word(16'hF0A9, 4'b1010);
        repeat (2 * FRAME + 2) tick();

        // Enable dropped mid-frame for 3 cycles, then restart from digit 0.
        repeat (13) tick();
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        repeat (FRAME + 6) tick();

        // Asynchronous reset while a digit is lit.
        while (!(n % PS >= BC + 1 && n % PS < PS - 1)) tick();
        #1 rst = 1'b1;
        #1;
        chk("async_rst_an", 32'(an), 32'hF);
        chk("async_rst_seg", 32'(seg), 32'h0);
        chk("async_rst_bcd", 32'(digit_bcd), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        en = 1'b0;
        repeat (4) tick();
        en = 1'b1;

        // Leading-zero patterns.
        load_word(16'h0040, 4'b0000);
        repeat (FRAME + 4) tick();
        load_word(16'h0000, 4'b0010);
        run_to_wrap_edge();
        tick();
        repeat (FRAME + 4) tick();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            logic [15:0] w;
            for (int k = 0; k < 4; k++)
                w[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            bcd_in = w;
            dp_in  = 4'($urandom_range(0, 15));
            load   = ($urandom_range(0, 9) == 0);
            en     = ($urandom_range(0, 59) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
